// File: rtl/gtech_aoi_pkg.sv
// Shared types and reduction helpers for the gtech_aoi_pipe complex-gate pipeline.
// The helpers work on one lane at a time, sized for the largest legal G and K.
package gtech_aoi_pkg;

  localparam int MAX_G  = 8;
  localparam int MAX_K  = 4;
  localparam int MAX_GK = MAX_G * MAX_K;

  typedef enum logic [1:0] {
    MODE_AOI = 2'b00,
    MODE_AO  = 2'b01,
    MODE_OAI = 2'b10,
    MODE_OA  = 2'b11
  } aoi_mode_t;

  // Modes 1x reduce OR inside a group and AND across groups; 0x the reverse.
  function automatic logic mode_or_first(input aoi_mode_t mode);
    logic [1:0] m;
    m = mode;
    return m[1];
  endfunction

  // Modes x0 invert the final result.
  function automatic logic mode_inverts(input aoi_mode_t mode);
    logic [1:0] m;
    m = mode;
    return ~m[0];
  endfunction

  // Picks one bit out of the flattened lane vector without a variable-width index.
  function automatic logic bit_at(input logic [MAX_GK-1:0] v, input int unsigned idx);
    logic [MAX_GK-1:0] s;
    s = v >> idx;
    return s[0];
  endfunction

  // Per-group partials for one lane: x[g*k_n + k] is input k of group g.
  function automatic logic [MAX_G-1:0] group_reduce(
    input logic [MAX_GK-1:0] x,
    input int unsigned       g_n,
    input int unsigned       k_n,
    input aoi_mode_t         mode
  );
    logic or_first;
    logic acc;
    // NOTE: every output bit and temporary gets a default before the loops, so no
    // path through the conditionals leaves anything unassigned (no latches).
    group_reduce = '0;
    or_first     = mode_or_first(mode);
    acc          = 1'b0;
    for (int g = 0; g < MAX_G; g++) begin
      if (g < int'(g_n)) begin
        acc = ~or_first;
        for (int k = 0; k < MAX_K; k++) begin
          if (k < int'(k_n)) begin
            if (or_first) acc = acc | bit_at(x, g * k_n + k);
            else          acc = acc & bit_at(x, g * k_n + k);
          end
        end
        group_reduce[g] = acc;
      end
    end
  endfunction

  // Combines the per-group partials of one lane into the lane's result bit.
  function automatic logic final_reduce(
    input logic [MAX_G-1:0] partials,
    input int unsigned      g_n,
    input aoi_mode_t        mode
  );
    logic or_first;
    logic acc;
    or_first = mode_or_first(mode);
    acc      = or_first;
    for (int g = 0; g < MAX_G; g++) begin
      if (g < int'(g_n)) begin
        if (or_first) acc = acc & partials[g];
        else          acc = acc | partials[g];
      end
    end
    return mode_inverts(mode) ? ~acc : acc;
  endfunction

endpackage

// File: rtl/gtech_aoi_pipe_stage.sv
// One elastic valid/ready register slice with a PW-bit payload. CLEAR_PAYLOAD
// selects whether the payload flops are reset (needed only where they drive ports).
module gtech_aoi_pipe_stage #(
  parameter int PW            = 8,
  parameter bit CLEAR_PAYLOAD = 1'b0
) (
  input  logic          CP,
  input  logic          CD,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_payload
);

  logic          valid_q;
  logic [PW-1:0] payload_q;
  logic          load;

  // The slice can take a beat when empty or when its current beat leaves now.
  assign in_ready = ~valid_q | out_ready;
  assign load     = in_valid & in_ready;

  // NOTE: state flops use non-blocking (<=) so every slice samples pre-edge
  // values and the chain shifts as one.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
    end
  end

  if (CLEAR_PAYLOAD) begin : g_clear
    always_ff @(posedge CP or negedge CD) begin
      if (!CD) begin
        payload_q <= '0;
      end else if (load) begin
        payload_q <= in_payload;
      end
    end
  end else begin : g_noclear
    // NOTE: internal data flops carry no reset; the valid bit alone says whether
    // their contents mean anything.
    always_ff @(posedge CP) begin
      if (load) begin
        payload_q <= in_payload;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = payload_q;

endmodule

// File: rtl/gtech_aoi_pipe.sv
// gtech_aoi_pipe: W-lane AOI/AO/OAI/OA complex gate over G groups of K inputs,
// carried through a STAGES-deep (1 or 2) elastic pipeline. Define GTECH_AOI_PIPE_PARITY_EN to add Z_PAR.
module gtech_aoi_pipe
  import gtech_aoi_pkg::*;
#(
  parameter int W      = 8,
  parameter int G      = 3,
  parameter int K      = 2,
  parameter int STAGES = 2
) (
  input  logic             CP,
  input  logic             CD,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [G*K*W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_mode,
  output logic [W-1:0]     Z
`ifdef GTECH_AOI_PIPE_PARITY_EN
  ,
  output logic             Z_PAR
`endif
);

  localparam int GK     = G * K;
  localparam int PART_W = G * W;
`ifdef GTECH_AOI_PIPE_PARITY_EN
  localparam int OUT_W  = W + 3;
`else
  localparam int OUT_W  = W + 2;
`endif

  // Gathers each lane's G*K operand bits and reduces them inside each group.
  // Partial for group g, lane l sits at bit g*W + l.
  function automatic logic [PART_W-1:0] calc_partials(
    input logic [GK*W-1:0] d,
    input aoi_mode_t       m
  );
    logic [MAX_GK-1:0] x;
    logic [MAX_G-1:0]  p;
    calc_partials = '0;
    for (int l = 0; l < W; l++) begin
      x = '0;
      for (int i = 0; i < GK; i++) x[i] = d[i*W + l];
      p = group_reduce(x, G, K, m);
      for (int g = 0; g < G; g++) calc_partials[g*W + l] = p[g];
    end
  endfunction

  // Combines the per-group partials across groups, lane by lane.
  function automatic logic [W-1:0] calc_result(
    input logic [PART_W-1:0] part,
    input aoi_mode_t         m
  );
    logic [MAX_G-1:0] p;
    calc_result = '0;
    for (int l = 0; l < W; l++) begin
      p = '0;
      for (int g = 0; g < G; g++) p[g] = part[g*W + l];
      calc_result[l] = final_reduce(p, G, m);
    end
  endfunction

  // Output slice payload layout: {[parity,] mode, Z}.
  function automatic logic [OUT_W-1:0] pack_out(
    input logic [W-1:0] z,
    input aoi_mode_t    m
  );
`ifdef GTECH_AOI_PIPE_PARITY_EN
    return {^z, m, z};
`else
    return {m, z};
`endif
  endfunction

  logic [OUT_W-1:0] out_payload;

  if (STAGES == 1) begin : g_single
    aoi_mode_t        mode_c;
    logic [OUT_W-1:0] result_c;

    assign mode_c   = aoi_mode_t'(in_mode);
    assign result_c = pack_out(calc_result(calc_partials(in_data, mode_c), mode_c), mode_c);

    gtech_aoi_pipe_stage #(
      .PW            (OUT_W),
      .CLEAR_PAYLOAD (1'b1)
    ) u_last (
      .CP          (CP),
      .CD          (CD),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_payload  (result_c),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_payload (out_payload)
    );
  end else begin : g_dual
    // Stage 1 holds {mode, partials}; stage 2 finishes the reduction into Z.
    aoi_mode_t         mode_c;
    logic [PART_W+1:0] s1_in;
    logic [PART_W+1:0] s1_out;
    logic              s1_valid;
    logic              s1_ready;
    aoi_mode_t         s1_mode;
    logic [OUT_W-1:0]  result_c;

    assign mode_c = aoi_mode_t'(in_mode);
    assign s1_in  = {in_mode, calc_partials(in_data, mode_c)};

    gtech_aoi_pipe_stage #(
      .PW            (PART_W + 2),
      .CLEAR_PAYLOAD (1'b0)
    ) u_s1 (
      .CP          (CP),
      .CD          (CD),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_payload  (s1_in),
      .out_valid   (s1_valid),
      .out_ready   (s1_ready),
      .out_payload (s1_out)
    );

    assign s1_mode  = aoi_mode_t'(s1_out[PART_W +: 2]);
    assign result_c = pack_out(calc_result(s1_out[PART_W-1:0], s1_mode), s1_mode);

    gtech_aoi_pipe_stage #(
      .PW            (OUT_W),
      .CLEAR_PAYLOAD (1'b1)
    ) u_s2 (
      .CP          (CP),
      .CD          (CD),
      .in_valid    (s1_valid),
      .in_ready    (s1_ready),
      .in_payload  (result_c),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_payload (out_payload)
    );
  end

  assign Z        = out_payload[W-1:0];
  assign out_mode = out_payload[W +: 2];
`ifdef GTECH_AOI_PIPE_PARITY_EN
  assign Z_PAR    = out_payload[W+2];
`endif

endmodule
